// File: rtl/hash_frame_pkg.sv
// Shared types and helpers for the hash frame assembler: FSM states,
// byte-lane placement and counter width derivation.
package hash_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam int DEFAULT_NUM_BYTES = 80;
  localparam int DEFAULT_BYTE_W    = 8;

  // Width of a counter that must hold every value 0..maxValue inclusive.
  function automatic int countWidth(input int maxValue);
    return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
  endfunction

  // Width of a counter that only needs to reach limit-1.
  function automatic int timerWidth(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

  // Swapped placement reverses byte order inside each 32-bit word.
  function automatic int laneIndex(input int idx, input bit swap);
    if (swap) begin
      return 4 * (idx / 4) + 3 - (idx % 4);
    end
    return idx;
  endfunction

  localparam int DEFAULT_COUNT_W = countWidth(DEFAULT_NUM_BYTES);

endpackage

// File: rtl/hash_frame_assembler_timeout.sv
// Inter-byte watchdog: restarts on activity, counts while enabled and pulses
// o_tc on the cycle the idle run reaches LIMIT clocks.
module frame_timeout_counter
  import hash_frame_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_enable,
  output logic o_tc
);

  localparam int CNT_W = timerWidth(LIMIT);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic             w_tc;

  assign w_tc = i_enable && !i_load && (r_count == TERMINAL);
  assign o_tc = w_tc;

  // Restarting on the terminal count keeps the counter inside its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load || !i_enable || w_tc) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE;
    end
  end

endmodule

// File: rtl/hash_frame_assembler.sv
// Collects NUM_BYTES received bytes into a frame and hands it to the hashing
// core over a valid/ready handshake, with abort, timeout and overrun handling.
module hash_frame_assembler
  import hash_frame_pkg::*;
#(
  parameter int NUM_BYTES   = 80,
  parameter int BYTE_W      = 8,
  parameter int WORD_SWAP   = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BYTE_W-1:0]             i_rx_data,
  input  logic                          i_rx_valid,
  input  logic                          i_rx_error,
  input  logic                          i_clear,
  output logic [NUM_BYTES*BYTE_W-1:0]   o_frame_data,
  output logic                          o_frame_valid,
  input  logic                          i_frame_ready,
  output logic [$clog2(NUM_BYTES+1)-1:0] o_byte_count,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic                          o_abort
);

  localparam int CNT_W = countWidth(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam bit SWAP = (WORD_SWAP != 0);

  state_t           r_state;
  logic [CNT_W-1:0] r_byteCount;
  logic             r_frameValid;
  logic             r_busy;
  logic             r_overrun;
  logic             r_abort;

  logic             w_timeout;
  logic             w_abortReq;
  logic             w_write;
  logic [CNT_W-1:0] w_wrIdx;
  int               w_wrLane;

  assign w_abortReq = (r_state == FILL) && (i_rx_error || w_timeout);

  // A byte is stored only where the FSM below accepts it.
  always_comb begin
    w_write = 1'b0;
    w_wrIdx = '0;
    if (!i_clear && i_rx_valid) begin
      case (r_state)
        IDLE: w_write = 1'b1;
        FILL: begin
          w_write = !w_abortReq;
          w_wrIdx = r_byteCount;
        end
        FULL:    w_write = i_frame_ready;
        default: w_write = 1'b0;
      endcase
    end
    w_wrLane = laneIndex(int'(w_wrIdx), SWAP);
  end

  for (genvar g = 0; g < NUM_BYTES; g++) begin : g_lane
    logic [BYTE_W-1:0] r_lane;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_lane <= '0;
      end else if (w_write && (w_wrLane == g)) begin
        r_lane <= i_rx_data;
      end
    end

    assign o_frame_data[g*BYTE_W +: BYTE_W] = r_lane;
  end

  if (TIMEOUT_CYC > 0) begin : g_timeout
    frame_timeout_counter #(
      .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .i_load  (i_rx_valid || i_clear),
      .i_enable(r_state == FILL),
      .o_tc    (w_timeout)
    );
  end else begin : g_noTimeout
    assign w_timeout = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_byteCount  <= '0;
      r_frameValid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort      <= 1'b0;
    end else if (i_clear) begin
      r_state      <= IDLE;
      r_byteCount  <= '0;
      r_frameValid <= 1'b0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_abort <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_rx_valid) begin
            r_byteCount <= ONE;
            if (NUM_BYTES == 1) begin
              r_state      <= FULL;
              r_frameValid <= 1'b1;
            end else begin
              r_state <= FILL;
              r_busy  <= 1'b1;
            end
          end
        end
        FILL: begin
          if (w_abortReq) begin
            r_state     <= IDLE;
            r_byteCount <= '0;
            r_busy      <= 1'b0;
            r_abort     <= 1'b1;
          end else if (i_rx_valid) begin
            r_byteCount <= r_byteCount + ONE;
            if (r_byteCount == LAST_IDX) begin
              r_state      <= FULL;
              r_busy       <= 1'b0;
              r_frameValid <= 1'b1;
            end
          end
        end
        FULL: begin
          // Handshake with a same-cycle byte starts the next frame without a bubble.
          if (i_frame_ready) begin
            if (i_rx_valid) begin
              r_byteCount <= ONE;
              if (NUM_BYTES != 1) begin
                r_state      <= FILL;
                r_busy       <= 1'b1;
                r_frameValid <= 1'b0;
              end
            end else begin
              r_state      <= IDLE;
              r_byteCount  <= '0;
              r_frameValid <= 1'b0;
            end
          end else if (i_rx_valid) begin
            r_overrun <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byteCount  <= '0;
          r_frameValid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign o_byte_count  = r_byteCount;
  assign o_frame_valid = r_frameValid;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_abort       = r_abort;

endmodule

// File: tb/tb_hash_frame_assembler.sv
// Testbench for hash_frame_assembler: an 80-byte plain instance and an 8-byte
// word-swapped instance with a 16-cycle timeout share one stimulus stream.
module tb_hash_frame_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxData;
  logic       rxValid;
  logic       rxError;
  logic       clear;
  logic       frameReady;

  logic [639:0] dataA;
  logic         validA, busyA, ovrA, abortA;
  logic [6:0]   countA;
  logic [63:0]  dataB;
  logic         validB, busyB, ovrB, abortB;
  logic [3:0]   countB;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hash_frame_assembler #(
    .NUM_BYTES(80), .BYTE_W(8), .WORD_SWAP(0), .TIMEOUT_CYC(0)
  ) dutA (
    .clk(clk), .rst(rst), .i_rx_data(rxData), .i_rx_valid(rxValid),
    .i_rx_error(rxError), .i_clear(clear), .o_frame_data(dataA),
    .o_frame_valid(validA), .i_frame_ready(frameReady), .o_byte_count(countA),
    .o_busy(busyA), .o_overrun(ovrA), .o_abort(abortA)
  );

  hash_frame_assembler #(
    .NUM_BYTES(8), .BYTE_W(8), .WORD_SWAP(1), .TIMEOUT_CYC(16)
  ) dutB (
    .clk(clk), .rst(rst), .i_rx_data(rxData), .i_rx_valid(rxValid),
    .i_rx_error(rxError), .i_clear(clear), .o_frame_data(dataB),
    .o_frame_valid(validB), .i_frame_ready(frameReady), .o_byte_count(countB),
    .o_busy(busyB), .o_overrun(ovrB), .o_abort(abortB)
  );

  // Reference model: a byte memory, a fill count, a "frame held" flag and
  // the number of idle cycles since the last byte, per instance.
  int         mNb[2]   = '{80, 8};
  bit         mSwap[2] = '{1'b0, 1'b1};
  int         mTmo[2]  = '{0, 16};
  logic [7:0] mMem[2][256];
  int         mCnt[2];
  bit         mHeld[2], mOvr[2], mAbt[2];
  int         mIdle[2];

  function automatic int laneOf(input int k, input int idx);
    if (mSwap[k]) return (idx & ~3) + (3 - (idx & 3));
    return idx;
  endfunction

  function automatic logic [639:0] modelData(input int k);
    logic [639:0] r;
    r = '0;
    for (int i = 0; i < mNb[k]; i++) r[8*i +: 8] = mMem[k][i];
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) mMem[k][i] = 8'h00;
      mCnt[k] = 0; mHeld[k] = 0; mOvr[k] = 0; mAbt[k] = 0; mIdle[k] = 0;
    end
  endtask

  task automatic storeByte(input int k);
    mMem[k][laneOf(k, mCnt[k])] = rxData;
    mCnt[k]  = mCnt[k] + 1;
    mIdle[k] = 0;
    mHeld[k] = (mCnt[k] == mNb[k]);
  endtask

  task automatic modelStep(input int k);
    bit filling;
    if (clear) begin
      mCnt[k] = 0; mHeld[k] = 0; mOvr[k] = 0; mAbt[k] = 0; mIdle[k] = 0;
      return;
    end
    mAbt[k] = 0;
    filling = !mHeld[k] && (mCnt[k] > 0);
    if (filling && (rxError || (mTmo[k] > 0 && !rxValid && mIdle[k] == mTmo[k] - 1))) begin
      mCnt[k] = 0; mAbt[k] = 1; mIdle[k] = 0;
    end else if (mHeld[k]) begin
      if (frameReady) begin
        mCnt[k] = 0; mHeld[k] = 0;
        if (rxValid) storeByte(k);
      end else if (rxValid) begin
        mOvr[k] = 1;
      end
    end else if (rxValid) begin
      storeByte(k);
    end else if (filling) begin
      mIdle[k] = mIdle[k] + 1;
    end
  endtask

  task automatic checkVal(input string name, input logic [639:0] act, input logic [639:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [639:0] expB;
    expB = modelData(1);
    checkVal("dataA",    dataA,              modelData(0));
    checkVal("countA",   640'(countA),       640'(mCnt[0]));
    checkVal("validA",   640'(validA),       640'(mHeld[0]));
    checkVal("busyA",    640'(busyA),        640'(!mHeld[0] && mCnt[0] > 0));
    checkVal("overrunA", 640'(ovrA),         640'(mOvr[0]));
    checkVal("abortA",   640'(abortA),       640'(mAbt[0]));
    checkVal("dataB",    640'(dataB),        640'(expB[63:0]));
    checkVal("countB",   640'(countB),       640'(mCnt[1]));
    checkVal("validB",   640'(validB),       640'(mHeld[1]));
    checkVal("busyB",    640'(busyB),        640'(!mHeld[1] && mCnt[1] > 0));
    checkVal("overrunB", 640'(ovrB),         640'(mOvr[1]));
    checkVal("abortB",   640'(abortB),       640'(mAbt[1]));
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                               input logic c, input logic r);
    rxValid = v; rxData = d; rxError = e; clear = c; frameReady = r;
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    checkOutput();
  endtask

  typedef struct packed {
    logic       rxv;
    logic [7:0] rxd;
    logic       err;
    logic       clr;
    logic       rdy;
    logic [6:0] expCount;
    logic       expBusy;
    logic       expAbort;
    logic [7:0] expLane0;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [639:0] expFill;
    int           abortSeen;
    int           abortAt;

    vecs[0]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, 8'h10};
    vecs[1]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, 8'h10};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd2, 1'b1, 1'b0, 8'h10};
    vecs[3]  = '{1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 7'd3, 1'b1, 1'b0, 8'h10};
    vecs[4]  = '{1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 7'd4, 1'b1, 1'b0, 8'h10};
    vecs[5]  = '{1'b1, 8'h14, 1'b0, 1'b0, 1'b0, 7'd5, 1'b1, 1'b0, 8'h10};
    vecs[6]  = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1, 8'h10};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 8'h10};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 8'h10};
    vecs[9]  = '{1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 7'd1, 1'b1, 1'b0, 8'h20};
    vecs[10] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 8'h20};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 8'h20};

    rst = 1'b1; rxData = '0; rxValid = 0; rxError = 0; clear = 0; frameReady = 0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput();

    for (int n = 0; n < 12; n++) begin
      applyStimulus(vecs[n].rxv, vecs[n].rxd, vecs[n].err, vecs[n].clr, vecs[n].rdy);
      checkVal("vecCount", 640'(countA),     640'(vecs[n].expCount));
      checkVal("vecBusy",  640'(busyA),      640'(vecs[n].expBusy));
      checkVal("vecAbort", 640'(abortA),     640'(vecs[n].expAbort));
      checkVal("vecLane0", 640'(dataA[7:0]), 640'(vecs[n].expLane0));
    end

    $display("[TB] full 80-byte frame");
    expFill = '0;
    for (int i = 0; i < 80; i++) begin
      expFill[8*i +: 8] = 8'(i);
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
      if (i == 78) checkVal("validEarly", 640'(validA), 640'(0));
    end
    checkVal("fillValid", 640'(validA),          640'(1));
    checkVal("fillLow",   640'(dataA[7:0]),      640'(8'h00));
    checkVal("fillHigh",  640'(dataA[639:632]),  640'(8'h4F));
    checkVal("fillCount", 640'(countA),          640'(80));

    applyStimulus(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    checkVal("ovrSet",  640'(ovrA), 640'(1));
    checkVal("ovrData", dataA,      expFill);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
    checkVal("bubbleCount", 640'(countA),     640'(1));
    checkVal("bubbleLane0", 640'(dataA[7:0]), 640'(8'hAA));
    checkVal("bubbleBusy",  640'(busyA),      640'(1));
    checkVal("ovrSticky",   640'(ovrA),       640'(1));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    checkVal("ovrCleared",  640'(ovrA),       640'(0));

    $display("[TB] word swap");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    checkVal("swapWord", 640'(dataB[31:0]), 640'(32'h11223344));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] abort on error");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkVal("errAbort", 640'(abortA), 640'(1));
    checkVal("errCount", 640'(countA), 640'(0));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkVal("errPulseEnd", 640'(abortA), 640'(0));
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    checkVal("refillValid", 640'(validA),          640'(1));
    checkVal("refillCount", 640'(countA),          640'(80));
    checkVal("refillHigh",  640'(dataA[639:632]),  640'(8'h7F));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkVal("handshakeIdle", 640'(validA), 640'(0));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] timeout");
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0);
    abortSeen = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (abortB) abortSeen++;
    end
    checkVal("gapNoAbort", 640'(abortSeen), 640'(0));
    applyStimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    checkVal("gapCount", 640'(countB), 640'(4));
    abortSeen = 0;
    abortAt = -1;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      if (abortB) begin
        abortSeen++;
        abortAt = i;
      end
    end
    checkVal("tmoPulses", 640'(abortSeen), 640'(1));
    checkVal("tmoAt",     640'(abortAt),   640'(15));
    checkVal("tmoBusy",   640'(busyB),     640'(0));
    checkVal("tmoCount",  640'(countB),    640'(0));
    checkVal("noTmoA",    640'(countA),    640'(4));
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(($urandom_range(0, 99) < ((i < 600) ? 60 : 15)),
                    8'($urandom),
                    ($urandom_range(0, 999) < 3),
                    ($urandom_range(0, 999) < 2),
                    ($urandom_range(0, 99) < 25));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    $display("[TB] asynchronous reset mid-fill");
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    checkVal("midCount", 640'(countA), 640'(40));
    rxValid = 0; rxError = 0; clear = 0; frameReady = 0;
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    checkVal("asyncCount", 640'(countA), 640'(0));
    checkVal("asyncData",  dataA,        640'(0));
    @(negedge clk);
    rst = 1'b0;
    checkOutput();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
